// File: rtl/booth_mac_accumulator_if.sv
// Handshake bundle between the Booth multiplier / job controller and the MAC accumulator.
interface booth_mac_accumulator_if #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned CNT_W  = 6
);
  logic              start;
  logic [CNT_W-1:0]  num_terms;
  logic [PROD_W-1:0] product;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc;
  logic              acc_valid;
  logic              acc_ready;
  logic              sat;
  logic              busy;

  modport master (
    output start, num_terms, product, prod_valid, acc_ready,
    input  prod_ready, acc, acc_valid, sat, busy
  );

  modport slave (
    input  start, num_terms, product, prod_valid, acc_ready,
    output prod_ready, acc, acc_valid, sat, busy
  );
endinterface

// File: rtl/booth_mac_accumulator.sv
// Saturating signed dot-product accumulator fed by the 4x4 Booth multiplier product stream.
// A job sums num_terms products; the result is held on acc until acc_ready is seen.
module booth_mac_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned CNT_W  = 6
) (
  input logic                    clk,
  input logic                    rst,
  booth_mac_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             prod_ready_q;
  logic             acc_valid_q;
  logic             busy_q;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_clamped;
  logic             sum_ovf;

  // Add in one guard bit; the top two bits disagreeing means the result left the ACC_W range.
  always_comb begin
    sum_ext     = {acc_q[ACC_W-1], acc_q} +
                  {{(ACC_W+1-PROD_W){bus.product[PROD_W-1]}}, bus.product};
    sum_clamped = sum_ext[ACC_W-1:0];
    sum_ovf     = 1'b0;
    unique case (sum_ext[ACC_W:ACC_W-1])
      2'b01: begin
        sum_clamped = AccMax;
        sum_ovf     = 1'b1;
      end
      2'b10: begin
        sum_clamped = AccMin;
        sum_ovf     = 1'b1;
      end
      default: ;
    endcase
  end

  // Job FSM; handshake flags are registered alongside the state so no output sees an input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.num_terms != '0) begin
              cnt_q        <= bus.num_terms;
              state_q      <= StAccum;
              prod_ready_q <= 1'b1;
            end else begin
              state_q     <= StDone;
              acc_valid_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (bus.prod_valid) begin
            acc_q <= sum_clamped;
            cnt_q <= cnt_q - CNT_W'(1);
            if (sum_ovf) sat_q <= 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q      <= StDone;
              prod_ready_q <= 1'b0;
              acc_valid_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          // start in this cycle is deliberately dropped; a new job needs a later IDLE cycle.
          if (bus.acc_ready) begin
            state_q     <= StIdle;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          prod_ready_q <= 1'b0;
          acc_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.busy       = busy_q;
  assign bus.acc        = acc_q;
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed self-checking bench for booth_mac_accumulator.
module tb_booth_mac_accumulator;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned CNT_W  = 6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  booth_mac_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  booth_mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: every test is a fixed number of cycles, so this only fires on a broken run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [CNT_W-1:0] n);
    bus.start     = 1'b1;
    bus.num_terms = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [PROD_W-1:0] v);
    bus.product    = v;
    bus.prod_valid = 1'b1;
    step();
    bus.prod_valid = 1'b0;
  endtask

  task automatic ack();
    bus.acc_ready = 1'b1;
    step();
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.acc !== 12'd0) begin bad++; $display("FAIL reset_acc: got %0d want 0", bus.acc); end
    total++; if (bus.acc_valid !== 1'b0) begin bad++; $display("FAIL reset_acc_valid: got %b want 0", bus.acc_valid); end
    total++; if (bus.prod_ready !== 1'b0) begin bad++; $display("FAIL reset_prod_ready: got %b want 0", bus.prod_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", bus.sat); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [PROD_W-1:0] vec [4];
    vec[0] = 8'd49; vec[1] = 8'(-56); vec[2] = 8'd16; vec[3] = 8'(-1);
    start_job(6'd4);
    total++; if (bus.prod_ready !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL basic_enter_accum: prod_ready=%b busy=%b want 1 1", bus.prod_ready, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      send(vec[i]);
      if (i == 2) begin
        total++; if (bus.acc_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", bus.acc_valid); end
      end
    end
    total++; if (bus.acc_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", bus.acc_valid); end
    total++; if (bus.acc !== 12'd8) begin bad++; $display("FAIL basic_acc: got %0d want 8", $signed(bus.acc)); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", bus.sat); end
    total++; if (bus.prod_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done: got %b want 0", bus.prod_ready); end
    ack();
    total++; if (bus.busy !== 1'b0 || bus.acc_valid !== 1'b0) begin
      bad++; $display("FAIL basic_idle: busy=%b acc_valid=%b want 0 0", bus.busy, bus.acc_valid);
    end
  endtask

  task automatic test_gaps();
    logic [PROD_W-1:0] vec [3];
    int                gap [3];
    logic [ACC_W-1:0]  exp_acc [3];
    vec[0] = 8'd10; vec[1] = 8'(-20); vec[2] = 8'd7;
    gap[0] = 0; gap[1] = 2; gap[2] = 5;
    exp_acc[0] = 12'd10; exp_acc[1] = 12'(-10); exp_acc[2] = 12'(-3);
    // Valid product while idle must be ignored.
    bus.product    = 8'd77;
    bus.prod_valid = 1'b1;
    step();
    bus.prod_valid = 1'b0;
    total++; if (bus.acc !== 12'd8 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL gaps_idle_ignore: acc=%0d busy=%b want 8 0", $signed(bus.acc), bus.busy);
    end
    start_job(6'd3);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        bus.product = 8'd99;
        step();
        total++; if (bus.acc !== (i == 0 ? 12'd0 : exp_acc[i-1]) || bus.prod_ready !== 1'b1) begin
          bad++; $display("FAIL gaps_stall: acc=%0d prod_ready=%b want %0d 1", $signed(bus.acc),
                          bus.prod_ready, $signed(exp_acc[i-1]));
        end
      end
      send(vec[i]);
      total++; if (bus.acc !== exp_acc[i]) begin
        bad++; $display("FAIL gaps_acc%0d: got %0d want %0d", i, $signed(bus.acc), $signed(exp_acc[i]));
      end
    end
    total++; if (bus.acc_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid: got %b want 1", bus.acc_valid); end
    ack();
  endtask

  task automatic test_saturation();
    start_job(6'd40);
    for (int i = 0; i < 40; i++) send(8'd64);
    total++; if (bus.acc !== 12'd2047 || bus.sat !== 1'b1) begin
      bad++; $display("FAIL sat_pos: acc=%0d sat=%b want 2047 1", $signed(bus.acc), bus.sat);
    end
    ack();
    start_job(6'd40);
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL sat_clear_on_start: got %b want 0", bus.sat); end
    for (int i = 0; i < 40; i++) send(8'(-56));
    total++; if (bus.acc !== 12'h800 || bus.sat !== 1'b1) begin
      bad++; $display("FAIL sat_neg: acc=%0d sat=%b want -2048 1", $signed(bus.acc), bus.sat);
    end
    ack();
    // Clamp, then pull back in range: 17*127 clamps to 2047, -128 gives 1919, sat stays set.
    start_job(6'd18);
    for (int i = 0; i < 17; i++) send(8'd127);
    send(8'(-128));
    total++; if (bus.acc !== 12'd1919 || bus.sat !== 1'b1) begin
      bad++; $display("FAIL sat_recover: acc=%0d sat=%b want 1919 1", $signed(bus.acc), bus.sat);
    end
    ack();
    total++; if (bus.sat !== 1'b1) begin bad++; $display("FAIL sat_sticky_idle: got %b want 1", bus.sat); end
    start_job(6'd2);
    send(8'd1);
    send(8'd1);
    total++; if (bus.acc !== 12'd2 || bus.sat !== 1'b0) begin
      bad++; $display("FAIL sat_next_job: acc=%0d sat=%b want 2 0", $signed(bus.acc), bus.sat);
    end
    ack();
  endtask

  task automatic test_zero_terms();
    bus.product    = 8'd50;
    bus.prod_valid = 1'b1;
    start_job(6'd0);
    total++; if (bus.acc_valid !== 1'b1 || bus.acc !== 12'd0) begin
      bad++; $display("FAIL zero_done: acc_valid=%b acc=%0d want 1 0", bus.acc_valid, $signed(bus.acc));
    end
    total++; if (bus.prod_ready !== 1'b0) begin bad++; $display("FAIL zero_ready: got %b want 0", bus.prod_ready); end
    step();
    total++; if (bus.prod_ready !== 1'b0 || bus.acc !== 12'd0) begin
      bad++; $display("FAIL zero_hold: prod_ready=%b acc=%0d want 0 0", bus.prod_ready, $signed(bus.acc));
    end
    bus.prod_valid = 1'b0;
    ack();
  endtask

  task automatic test_backpressure();
    start_job(6'd1);
    send(8'd5);
    for (int i = 0; i < 5; i++) begin
      bus.start     = (i == 2);
      bus.num_terms = 6'd3;
      step();
      bus.start = 1'b0;
      total++; if (bus.acc_valid !== 1'b1 || bus.acc !== 12'd5 || bus.prod_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: acc_valid=%b acc=%0d prod_ready=%b want 1 5 0", i,
                        bus.acc_valid, $signed(bus.acc), bus.prod_ready);
      end
    end
    // start coinciding with the accept handshake is dropped.
    bus.acc_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.acc_ready = 1'b0;
    bus.start     = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.acc_valid !== 1'b0) begin
      bad++; $display("FAIL bp_to_idle: busy=%b acc_valid=%b want 0 0", bus.busy, bus.acc_valid);
    end
    step();
    total++; if (bus.busy !== 1'b0 || bus.prod_ready !== 1'b0) begin
      bad++; $display("FAIL bp_start_ignored: busy=%b prod_ready=%b want 0 0", bus.busy, bus.prod_ready);
    end
  endtask

  task automatic test_reset_midjob();
    start_job(6'd5);
    send(8'd10);
    send(8'd10);
    total++; if (bus.acc !== 12'd20) begin bad++; $display("FAIL midjob_partial: got %0d want 20", $signed(bus.acc)); end
    rst = 1'b1;
    #1;
    total++; if (bus.acc !== 12'd0 || bus.busy !== 1'b0 || bus.prod_ready !== 1'b0 ||
                 bus.acc_valid !== 1'b0 || bus.sat !== 1'b0) begin
      bad++; $display("FAIL midjob_async_reset: acc=%0d busy=%b prod_ready=%b acc_valid=%b sat=%b want all 0",
                      $signed(bus.acc), bus.busy, bus.prod_ready, bus.acc_valid, bus.sat);
    end
    step();
    rst = 1'b0;
    step();
    total++; if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL midjob_no_result: acc_valid=%b busy=%b want 0 0", bus.acc_valid, bus.busy);
    end
    start_job(6'd1);
    send(8'(-8));
    total++; if (bus.acc !== 12'(-8) || bus.acc_valid !== 1'b1) begin
      bad++; $display("FAIL midjob_next_job: acc=%0d acc_valid=%b want -8 1", $signed(bus.acc), bus.acc_valid);
    end
    ack();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_terms  = '0;
    bus.product    = '0;
    bus.prod_valid = 1'b0;
    bus.acc_ready  = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_zero_terms();
    test_backpressure();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
